multicycle_alu: RTL and testbench
=================================

# multicycle_alu

Parametrised, multi-cycle successor to the datapath's combinational 32-bit ALU. It keeps the same 12-bit one-hot control encoding and the ZHI/ZLO result pair, and adds several things:
- a start/busy/done handshake;
- iterative shift-add multiply and restoring divide, so the block closes timing at any WIDTH;
- a divide-by-zero / illegal-control error flag.

It sits between the register-file operand latches (A, B) and the Z result registers, driven by the control unit.

## Interface
- WIDTH, 32, operand and result width; power of two, 8..64
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- ctrl  input  12  one-hot op select: [11] not, [10] negate, [9] divide, [8] multiply, [7] or, [6] and, [5] rotate left, [4] rotate right, [3] shift left, [2] shift right (logical), [1] subtract, [0] add
- A  input  WIDTH  operand A (dividend, multiplicand, shift source)
- B  input  WIDTH  operand B (divisor, multiplier, shift amount)
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when ZHI/ZLO/err become valid
- err  output  1  divide by zero or ctrl not exactly one-hot; valid with done
- ZHI  output  WIDTH  high result: product[2W-1:W] or remainder, else 0
- ZLO  output  WIDTH  low result: product[W-1:0], quotient, or single-cycle result

## Operation
- States: IDLE, MUL, DIV, DONE. Reset (clr high, any time) forces IDLE with busy=0, done=0, err=0, ZHI=0, ZLO=0, and clears all iteration registers.
- Acceptance: in IDLE, start=1 latches A, B and ctrl at the clock edge. start while busy or in DONE is ignored; operands are not re-sampled.
- Single-cycle ops (all except [9] and [8]): the result is computed from the latched operands and goes to DONE. ZHI=0.
- Shift and rotate amounts use B[SHW-1:0], i.e. B mod WIDTH. A rotate or shift by 0 returns A unchanged; there is no WIDTH-bit shift hazard.
- Negate = ~A+1 and add/sub wrap modulo 2^WIDTH. No carry or overflow output.
- Multiply (unsigned): IDLE→MUL with the counter set to WIDTH. Each cycle adds the multiplicand to the upper accumulator half if the current multiplier LSB is 1, then shifts right. Counter hits 0 → DONE, giving the full 2·WIDTH-bit product.
- Divide (unsigned restoring): IDLE→DIV, one quotient bit per cycle, WIDTH cycles → DONE. Quotient goes to ZLO, remainder to ZHI.
- Divide with B=0: no DIV iterations. IDLE→DONE with err=1, ZLO all ones, ZHI=A.
- Illegal ctrl (zero or multiple bits set): IDLE→DONE with err=1, ZHI=ZLO=0.
- DONE: done=1 for exactly one cycle, then IDLE. ZHI, ZLO and err hold until the next accepted start's result overwrites them.

## Timing
- Start accepted at edge N. busy is 1 in the cycles after edges N .. N+L-1 and low from edge N+L. done is 1 in the cycle after edge N+L.
- Latency L is:
  - 1 for single-cycle ops, divide-by-zero and illegal ctrl;
  - WIDTH+1 for multiply and divide.
- Back-to-back: start may be reasserted in the cycle done is high. It is accepted on the following edge (from IDLE), so the minimum issue interval is L+1 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- MULTICYCLE_ALU_FAST_MUL_EN defined: multiply uses a single combinational WIDTH×WIDTH product, skips MUL and has L=1. Divide is unchanged.
- Not defined: iterative multiply as above, L=WIDTH+1.
- Results are bit-identical in both builds; only latency differs.

## Test plan
- Reset mid-multiply:
  - Stimulus: WIDTH=32, start mul A=0xFFFF_FFFF B=0xFFFF_FFFF, clr asserted at cycle 10.
  - Required: busy/done/ZHI/ZLO go to 0 immediately.
  - Then rerun the same op after reset. Required: done at cycle 33, ZHI=0xFFFF_FFFE, ZLO=0x0000_0001.
- Divide:
  - A=100, B=7. Required: done at L=33, ZLO=14, ZHI=2, err=0.
  - A=5, B=0. Required: done at L=1, err=1, ZLO=0xFFFF_FFFF, ZHI=5.
- Shifts/rotates, A=0x8000_0001:
  - rotate left, B=1 → ZLO=0x0000_0003;
  - rotate right, B=0 → ZLO=0x8000_0001;
  - shift left, B=33 → ZLO=0x0000_0002 (amount mod 32);
  - shift right, B=31 → ZLO=0x0000_0001.
- Error and wrap handling:
  - ctrl=0x003 → err=1, ZHI=ZLO=0, L=1.
  - ctrl=0x000 → same response.
  - negate A=0 → ZLO=0.
  - sub 0−1 → ZLO=0xFFFF_FFFF.
- Handshake:
  - Issue div, then pulse start with add during busy. Required: add ignored, div result returned.
  - Hold start high through done. Required: next op accepted the cycle after done, with fresh operands latched.
- Builds: rerun the multiply cases with MULTICYCLE_ALU_FAST_MUL_EN and WIDTH=8.
  - A=0xFF, B=0x02. Required: ZHI=0x01, ZLO=0xFE.
  - Required latency: 1 with the macro, 9 without.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: one-hot ctrl, start/busy/done handshake, iterative multiply/divide.
// Define MULTICYCLE_ALU_FAST_MUL_EN for a single-cycle combinational multiply.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [11:0]      ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] ZHI,
  output logic [WIDTH-1:0] ZLO
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg, b_reg, hi_reg, lo_reg;
  logic [11:0]      op_reg;
  logic [SHW:0]     count_reg;

  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] rotl_wide, rotr_wide;
  logic [WIDTH-1:0]   single_res;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               res_err;

  function automatic logic one_hot(input logic [11:0] v);
    return (v != 12'd0) && ((v & (v - 12'd1)) == 12'd0);
  endfunction

  // Rotates via a doubled operand so a zero amount never needs a WIDTH-bit shift
  always_comb begin
    shamt     = b_reg[SHW-1:0];
    rotl_wide = {a_reg, a_reg} << shamt;
    rotr_wide = {a_reg, a_reg} >> shamt;
    case (op_reg)
      12'h001: single_res = a_reg + b_reg;
      12'h002: single_res = a_reg - b_reg;
      12'h004: single_res = a_reg >> shamt;
      12'h008: single_res = a_reg << shamt;
      12'h010: single_res = rotr_wide[WIDTH-1:0];
      12'h020: single_res = rotl_wide[2*WIDTH-1:WIDTH];
      12'h040: single_res = a_reg & b_reg;
      12'h080: single_res = a_reg | b_reg;
      12'h400: single_res = ~a_reg + WIDTH'(1);
      12'h800: single_res = ~a_reg;
      default: single_res = '0;
    endcase
  end

  // One shift-add multiply step and one restoring-divide step
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_reg};
  end

`ifdef MULTICYCLE_ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  always_comb fast_prod = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};
`endif

  always_comb begin
    res_hi  = '0;
    res_lo  = '0;
    res_err = 1'b0;
    if (!one_hot(op_reg)) begin
      res_err = 1'b1;
    end else if (op_reg[9]) begin
      if (b_reg == '0) begin
        res_err = 1'b1;
        res_hi  = a_reg;
        res_lo  = '1;
      end else begin
        res_hi = hi_reg;
        res_lo = lo_reg;
      end
    end else if (op_reg[8]) begin
`ifdef MULTICYCLE_ALU_FAST_MUL_EN
      res_hi = fast_prod[2*WIDTH-1:WIDTH];
      res_lo = fast_prod[WIDTH-1:0];
`else
      res_hi = hi_reg;
      res_lo = lo_reg;
`endif
    end else begin
      res_lo = single_res;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      op_reg    <= '0;
      count_reg <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ZHI       <= '0;
      ZLO       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= A;
            b_reg     <= B;
            op_reg    <= ctrl;
            busy      <= 1'b1;
            hi_reg    <= '0;
            count_reg <= CNT_INIT;
            state     <= DONE;
`ifndef MULTICYCLE_ALU_FAST_MUL_EN
            if (one_hot(ctrl) && ctrl[8]) begin
              lo_reg <= B;
              state  <= MUL;
            end
`endif
            if (one_hot(ctrl) && ctrl[9] && (B != '0)) begin
              lo_reg <= A;
              state  <= DIV;
            end
          end
        end
        MUL: begin
          hi_reg    <= mul_sum[WIDTH:1];
          lo_reg    <= {mul_sum[0], lo_reg[WIDTH-1:1]};
          count_reg <= count_reg - CNT_ONE;
          if (count_reg == CNT_ONE) state <= DONE;
        end
        DIV: begin
          // A clear top bit means the trial subtraction did not borrow
          if (!div_diff[WIDTH]) begin
            hi_reg <= div_diff[WIDTH-1:0];
            lo_reg <= {lo_reg[WIDTH-2:0], 1'b1};
          end else begin
            hi_reg <= div_shift[WIDTH-1:0];
            lo_reg <= {lo_reg[WIDTH-2:0], 1'b0};
          end
          count_reg <= count_reg - CNT_ONE;
          if (count_reg == CNT_ONE) state <= DONE;
        end
        DONE: begin
          ZHI   <= res_hi;
          ZLO   <= res_lo;
          err   <= res_err;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: random and directed ops vs. an arithmetic reference model.
module tb_multicycle_alu;
  localparam int W = 32;
`ifdef MULTICYCLE_ALU_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL8_LAT = 1;
`else
  localparam int MUL_LAT  = W + 1;
  localparam int MUL8_LAT = 9;
`endif

  typedef struct {
    logic [11:0]  c;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  logic         clk = 1'b0, clr = 1'b1, start = 1'b0;
  logic [11:0]  ctrl = '0;
  logic [W-1:0] A = '0, B = '0;
  logic         busy, done, err;
  logic [W-1:0] ZHI, ZLO;

  logic         start8 = 1'b0;
  logic [11:0]  ctrl8 = '0;
  logic [7:0]   A8 = '0, B8 = '0;
  logic         busy8, done8, err8;
  logic [7:0]   ZHI8, ZLO8;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .ctrl(ctrl), .A(A), .B(B),
    .busy(busy), .done(done), .err(err), .ZHI(ZHI), .ZLO(ZLO)
  );

  multicycle_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .clr(clr), .start(start8), .ctrl(ctrl8), .A(A8), .B(B8),
    .busy(busy8), .done(done8), .err(err8), .ZHI(ZHI8), .ZLO(ZLO8)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   txn = 0;
  bit   mon_en = 1'b1;
  exp_t sb[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Reference model: plain arithmetic on the spec's rules
  function automatic exp_t model(input logic [11:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [63:0]  p;
    logic [W-1:0] r;
    int           s;
    e.c = c; e.hi = '0; e.lo = '0; e.err = 1'b0; e.lat = 1; e.acc = 0;
    s = int'(b % W);
    r = a;
    if ($countones(c) != 1) begin
      e.err = 1'b1;
      return e;
    end
    case (c)
      12'h001: e.lo = a + b;
      12'h002: e.lo = a - b;
      12'h004: e.lo = a >> s;
      12'h008: e.lo = a << s;
      12'h010: begin
        repeat (s) r = (r >> 1) | ((r & 32'd1) << (W - 1));
        e.lo = r;
      end
      12'h020: begin
        repeat (s) r = (r << 1) | (r >> (W - 1));
        e.lo = r;
      end
      12'h040: e.lo = a & b;
      12'h080: e.lo = a | b;
      12'h100: begin
        p = 64'(a) * 64'(b);
        e.hi = p[63:32];
        e.lo = p[31:0];
        e.lat = MUL_LAT;
      end
      12'h200: begin
        if (b == 0) begin
          e.err = 1'b1; e.hi = a; e.lo = '1;
        end else begin
          e.lo = a / b; e.hi = a % b; e.lat = W + 1;
        end
      end
      12'h400: e.lo = 32'd0 - a;
      default: e.lo = ~a;
    endcase
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (mon_en && !clr && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        mon_e = sb.pop_front();
        txn++;
        chk("zhi", 64'(ZHI), 64'(mon_e.hi));
        chk("zlo", 64'(ZLO), 64'(mon_e.lo));
        chk("err", 64'(err), 64'(mon_e.err));
        chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
        chk("busy_at_done", 64'(busy), 64'd0);
        $display("txn %0d ctrl=%03h zhi=%08h zlo=%08h err=%0b lat=%0d",
                 txn, mon_e.c, ZHI, ZLO, err, cyc - mon_e.acc);
      end
    end
  end

  task automatic issue(input logic [11:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(c, a, b);
    start = 1'b1; ctrl = c; A = a; B = b;
    @(posedge clk); #1;
    e.acc = cyc;
    sb.push_back(e);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk); #1;
      t++;
    end while (sb.size() != 0 && t < 100);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=%0d_pending expected=0_pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic run8(input logic [11:0] c, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ehi, input logic [7:0] elo, input int elat);
    int acc8, t;
    @(negedge clk); #1;
    start8 = 1'b1; ctrl8 = c; A8 = a; B8 = b;
    @(posedge clk); #1;
    acc8 = cyc;
    start8 = 1'b0;
    t = 0;
    while (!done8 && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("w8_done", 64'(done8), 64'd1);
    chk("w8_zhi", 64'(ZHI8), 64'(ehi));
    chk("w8_zlo", 64'(ZLO8), 64'(elo));
    chk("w8_err", 64'(err8), 64'd0);
    chk("w8_latency", 64'(cyc - acc8), 64'(elat));
    $display("txn w8 ctrl=%03h zhi=%02h zlo=%02h lat=%0d", c, ZHI8, ZLO8, cyc - acc8);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    exp_t        e1, e2;
    int          t;
    logic [11:0] c;
    logic [W-1:0] ra, rb;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_zhi", 64'(ZHI), 64'd0);
    chk("rst_zlo", 64'(ZLO), 64'd0);
    @(negedge clk); #1;
    clr = 1'b0;
    @(negedge clk); #1;

    // Directed cases
    issue(12'h200, 32'd100, 32'd7);                 wait_idle();
    issue(12'h200, 32'd5, 32'd0);                   wait_idle();
    issue(12'h020, 32'h8000_0001, 32'd1);           wait_idle();
    issue(12'h010, 32'h8000_0001, 32'd0);           wait_idle();
    issue(12'h008, 32'h8000_0001, 32'd33);          wait_idle();
    issue(12'h004, 32'h8000_0001, 32'd31);          wait_idle();
    issue(12'h003, 32'h1234_5678, 32'h9abc_def0);   wait_idle();
    issue(12'h000, 32'h1234_5678, 32'h9abc_def0);   wait_idle();
    issue(12'h400, 32'd0, 32'd3);                   wait_idle();
    issue(12'h002, 32'd0, 32'd1);                   wait_idle();
    issue(12'h001, 32'hffff_ffff, 32'd1);           wait_idle();
    issue(12'h100, 32'hffff_ffff, 32'hffff_ffff);   wait_idle();

    // Reset in the middle of a multiply
    mon_en = 1'b0;
    start = 1'b1; ctrl = 12'h100; A = '1; B = '1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    clr = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_zhi", 64'(ZHI), 64'd0);
    chk("midrst_zlo", 64'(ZLO), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    @(negedge clk); #1;
    clr = 1'b0;
    mon_en = 1'b1;
    issue(12'h100, 32'hffff_ffff, 32'hffff_ffff);   wait_idle();

    // Start pulsed while busy must be ignored, operands not re-sampled
    issue(12'h200, 32'd1000, 32'd9);
    repeat (3) @(negedge clk);
    #1;
    start = 1'b1; ctrl = 12'h001; A = 32'd1; B = 32'd2;
    @(negedge clk); #1;
    start = 1'b0; A = '0; B = '0;
    wait_idle();
    repeat (5) @(negedge clk);
    #1;

    // Start held high through done: next op taken the edge after done
    start = 1'b1; ctrl = 12'h100; A = 32'hdead_beef; B = 32'h0001_0003;
    e1 = model(12'h100, 32'hdead_beef, 32'h0001_0003);
    @(posedge clk); #1;
    e1.acc = cyc;
    sb.push_back(e1);
    ctrl = 12'h002; A = 32'd50; B = 32'd80;
    t = 0;
    while (!done && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("hold_done_seen", 64'(done), 64'd1);
    @(posedge clk); #1;
    e2 = model(12'h002, 32'd50, 32'd80);
    e2.acc = cyc;
    sb.push_back(e2);
    start = 1'b0;
    wait_idle();

    // Randomized traffic, issued back-to-back as soon as each result lands
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 8) c = 12'd1 << $urandom_range(0, 11);
      else                          c = 12'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = $urandom_range(1, 40);
        default: rb = $urandom;
      endcase
      issue(c, ra, rb);
      wait_idle();
    end

    // Narrow build
    run8(12'h100, 8'hFF, 8'h02, 8'h01, 8'hFE, MUL8_LAT);
    run8(12'h200, 8'hFF, 8'h10, 8'h0F, 8'h0F, 9);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
